// File: rtl/iob_sync_fifo_asym.sv
// Single-clock FIFO with independent write/read widths, stored as narrow words.
// Define IOB_SYNC_FIFO_ASYM_FWFT_EN for first-word fall-through (0-latency) reads.
module iob_sync_fifo_asym #(
  parameter int W_DATA_W   = 32,
  parameter int R_DATA_W   = 32,
  parameter int ADDR_W     = 8,
  parameter int AFULL_LVL  = 2 ** (ADDR_W - 1),
  parameter int AEMPTY_LVL = 1,
  localparam int MINW     = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MAXW     = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int R_LOG    = $clog2(MAXW / MINW),
  localparam int W_LOG    = (W_DATA_W > R_DATA_W) ? R_LOG : 0,
  localparam int RD_LOG   = (R_DATA_W > W_DATA_W) ? R_LOG : 0,
  localparam int W_ADDR_W = ADDR_W - W_LOG,
  localparam int R_ADDR_W = ADDR_W - RD_LOG
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write_en,
  input  logic [W_DATA_W-1:0] data_in,
  output logic                full,
  output logic                almost_full,
  output logic [W_ADDR_W:0]   level_w,
  output logic                w_err,
  input  logic                read_en,
  output logic [R_DATA_W-1:0] data_out,
  output logic                empty,
  output logic                almost_empty,
  output logic [R_ADDR_W:0]   level_r,
  output logic                r_err
);

  localparam int WS = 1 << W_LOG;
  localparam int RS = 1 << RD_LOG;
  localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WS_C     = (ADDR_W + 1)'(WS);
  localparam logic [ADDR_W:0]   RS_C     = (ADDR_W + 1)'(RS);
  localparam logic [W_ADDR_W:0] AFULL_C  = (W_ADDR_W + 1)'(AFULL_LVL);
  localparam logic [R_ADDR_W:0] AEMPTY_C = (R_ADDR_W + 1)'(AEMPTY_LVL);

  logic [ADDR_W:0]     wptr_reg, rptr_reg;
  logic [ADDR_W:0]     occ, free_slots;
  logic [ADDR_W-1:0]   waddr, raddr;
  logic                wr_acc, rd_acc;
  logic                w_err_reg, r_err_reg;
  logic [R_DATA_W-1:0] rd_word;
  logic [MINW-1:0]     mem [2**ADDR_W];

  // Pointer difference is exact thanks to the extra wrap bit.
  assign occ        = wptr_reg - rptr_reg;
  assign free_slots = DEPTH_C - occ;
  assign full       = (free_slots < WS_C);
  assign empty      = (occ < RS_C);
  assign level_w    = occ[ADDR_W:W_LOG];
  assign level_r    = occ[ADDR_W:RD_LOG];
  assign almost_full  = (level_w >= AFULL_C);
  assign almost_empty = (level_r <= AEMPTY_C);
  assign w_err      = w_err_reg;
  assign r_err      = r_err_reg;

  assign wr_acc = write_en & ~full;
  assign rd_acc = read_en & ~empty;
  assign waddr  = wptr_reg[ADDR_W-1:0];
  assign raddr  = rptr_reg[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      w_err_reg <= 1'b0;
      r_err_reg <= 1'b0;
    end else begin
      if (wr_acc) wptr_reg <= wptr_reg + WS_C;
      if (rd_acc) rptr_reg <= rptr_reg + RS_C;
      w_err_reg <= write_en & full;
      r_err_reg <= read_en & empty;
    end
  end

  // Wide writes are split LSB-first into consecutive narrow slots.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < WS; i++) begin
        mem[waddr + ADDR_W'(i)] <= data_in[i*MINW +: MINW];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RS; gi++) begin : g_rd_lane
      assign rd_word[gi*MINW +: MINW] = mem[raddr + ADDR_W'(gi)];
    end
  endgenerate

`ifdef IOB_SYNC_FIFO_ASYM_FWFT_EN
  assign data_out = rd_word;
`else
  logic [R_DATA_W-1:0] data_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg <= '0;
    end else if (rd_acc) begin
      data_out_reg <= rd_word;
    end
  end

  assign data_out = data_out_reg;
`endif

endmodule
